// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic units (divider FSM states,
// default operand width, magnitude helper, iteration-counter sizing).
package arith_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  // Counter must reach WIDTH itself, hence WIDTH+1 distinct values.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  // Magnitude of a w-bit two's-complement value held in the low bits of v.
  // The most-negative value maps to 2**(w-1), which still fits w unsigned bits.
  function automatic logic [63:0] abs_val(input logic [63:0] v, input int w);
    logic [63:0] mask;
    mask = {64{1'b1}} >> (64 - w);
    if (v[w-1]) return (~v + 64'd1) & mask;
    return v & mask;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor magnitude if it fits. Purely combinational.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] dsr,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  // One extra bit so the shifted partial remainder can never overflow.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_in, bit_in};
  assign diff    = shifted - {1'b0, dsr};
  assign q_bit   = (shifted >= {1'b0, dsr});
  // After a step the remainder is below the divisor, so it fits WIDTH bits.
  assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential radix-2 restoring divider: one quotient bit per clock, done pulse
// WIDTH+1 cycles after the accepted start (1 cycle for divide-by-zero).
module seq_divider
  import arith_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] prem;
  logic [WIDTH-1:0] dvd_sh;
  logic [WIDTH-1:0] dsr_mag;
  logic             sign_q, sign_r, zero_dsr;

  logic [WIDTH-1:0] dvd_in_mag, dsr_in_mag;
  logic             sign_q_in, sign_r_in, zero_in;
  logic [WIDTH-1:0] prem_nxt;
  logic             q_bit;
  logic [WIDTH-1:0] q_res, r_res;
  logic             steps_done;

  generate
    if (SIGNED) begin : g_signed
      assign dvd_in_mag = WIDTH'(abs_val(64'(dividend), WIDTH));
      assign dsr_in_mag = WIDTH'(abs_val(64'(divisor), WIDTH));
      assign sign_q_in  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      assign sign_r_in  = dividend[WIDTH-1];
    end else begin : g_unsigned
      assign dvd_in_mag = dividend;
      assign dsr_in_mag = divisor;
      assign sign_q_in  = 1'b0;
      assign sign_r_in  = 1'b0;
    end
  endgenerate

  assign zero_in    = (divisor == '0);
  assign steps_done = (cnt == LAST);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (prem),
    .bit_in  (dvd_sh[WIDTH-1]),
    .dsr     (dsr_mag),
    .rem_out (prem_nxt),
    .q_bit   (q_bit)
  );

  always_comb begin
    state_nxt = state;
    q_res     = sign_q ? (~dvd_sh + WIDTH'(1)) : dvd_sh;
    r_res     = sign_r ? (~prem + WIDTH'(1)) : prem;
    if (zero_dsr) begin
      q_res = '1;
      r_res = dvd_sh;
    end
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (steps_done) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // dvd_sh shifts the dividend out of its top while quotient bits enter at
  // the bottom; a zero divisor skips straight to the final RUN cycle with the
  // raw dividend parked in dvd_sh so it can be returned as the remainder.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      prem        <= '0;
      dvd_sh      <= '0;
      dsr_mag     <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      zero_dsr    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            prem        <= '0;
            zero_dsr    <= zero_in;
            dsr_mag     <= dsr_in_mag;
            cnt         <= zero_in ? LAST : '0;
            dvd_sh      <= zero_in ? dividend : dvd_in_mag;
            sign_q      <= zero_in ? 1'b0 : sign_q_in;
            sign_r      <= zero_in ? 1'b0 : sign_r_in;
          end
        end
        RUN: begin
          if (steps_done) begin
            done        <= 1'b1;
            quotient    <= q_res;
            remainder   <= r_res;
            div_by_zero <= zero_dsr;
          end else begin
            prem   <= prem_nxt;
            dvd_sh <= {dvd_sh[WIDTH-2:0], q_bit};
            cnt    <= cnt + CW'(1);
          end
        end
        FINISH: busy <= 1'b0;
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule
